// File: rtl/dap_cmd_decoder.sv
// ---------------------------------------------------------------------------
// dap_cmd_decoder
//
// Request-side command decoder for the CMSIS-DAP datapath. It sits directly
// behind the USB receiver's byte-wide AXI-Stream output. It collects one
// command ID byte plus that command's fixed number of argument bytes, then
// presents them to the DAP executor as one parallel command word through a
// valid/ready handshake. An unsupported ID raises a one-cycle error pulse.
// The rest of that USB packet is then drained until the receiver FIFO reports
// empty and no byte is being offered.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   resetn         synchronous active-low reset
//   s_axis_tvaild  request byte valid from the receiver
//   s_axis_tdata   request byte
//   s_axis_tready  byte accepted when tready && tvaild at a clock edge
//   src_empty      receiver FIFO empty flag, only looked at while draining
//   cmd_valid      decoded command available
//   cmd_ready      executor accepts the command
//   cmd_id         command ID byte
//   cmd_len        number of argument bytes (0..5)
//   cmd_arg        argument bytes, little-endian, unused bytes read 0
//   cmd_err        one-cycle pulse when an unsupported ID is accepted
//   err_id         last unsupported ID, held until the next error
// ---------------------------------------------------------------------------
module dap_cmd_decoder (
   input  logic        clk,
   input  logic        resetn,
   input  logic        s_axis_tvaild,
   input  logic [7:0]  s_axis_tdata,
   output logic        s_axis_tready,
   input  logic        src_empty,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [7:0]  cmd_id,
   output logic [2:0]  cmd_len,
   output logic [39:0] cmd_arg,
   output logic        cmd_err,
   output logic [7:0]  err_id
);

   // Decoder states: waiting for an ID, collecting arguments, holding a
   // finished command for the executor, and discarding an unsupported packet.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARGS  = 2'd1,
      ST_OUT   = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic        tready_q, tready_d;
   logic        cmdValid_q, cmdValid_d;
   logic [7:0]  cmdId_q, cmdId_d;
   logic [2:0]  cmdLen_q, cmdLen_d;
   logic [39:0] cmdArg_q, cmdArg_d;
   logic        cmdErr_q, cmdErr_d;
   logic [7:0]  errId_q, errId_d;
   logic [2:0]  cnt_q, cnt_d;

   logic        accept;
   logic [3:0]  lookup;
   logic        idSupported;
   logic [2:0]  idLen;

   // Fixed command table. The top bit flags a supported ID and the low three
   // bits give its argument byte count. Unknown IDs report length 0.
   function automatic logic [3:0] lookupCmd(input logic [7:0] id);
      logic [3:0] res;
      case (id)
         8'h00:   res = 4'b1_001;
         8'h01:   res = 4'b1_010;
         8'h02:   res = 4'b1_001;
         8'h03:   res = 4'b1_000;
         8'h04:   res = 4'b1_101;
         8'h08:   res = 4'b1_101;
         8'h09:   res = 4'b1_010;
         8'h0A:   res = 4'b1_000;
         8'h11:   res = 4'b1_100;
         8'h13:   res = 4'b1_001;
         default: res = 4'b0_000;
      endcase
      return res;
   endfunction

   // A byte moves only when the registered ready and the source valid are
   // both high. tready is a pure function of the state register, so this is
   // safe to use for the next-state decision.
   assign accept      = tready_q & s_axis_tvaild;
   assign lookup      = lookupCmd(s_axis_tdata);
   assign idSupported = lookup[3];
   assign idLen       = lookup[2:0];

   // Next-state and next-output logic. Every register keeps its value unless
   // a branch below changes it. cmd_err defaults low so it can only pulse.
   // tready and cmd_valid are derived from the next state. That keeps both of
   // them registered and locked to the state they describe.
   always_comb begin
      state_d    = state_q;
      cmdId_d    = cmdId_q;
      cmdLen_d   = cmdLen_q;
      cmdArg_d   = cmdArg_q;
      cmdErr_d   = 1'b0;
      errId_d    = errId_q;
      cnt_d      = cnt_q;
      tready_d   = 1'b1;
      cmdValid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cmdId_d  = s_axis_tdata;
               cmdLen_d = idLen;
               cmdArg_d = 40'd0;
               cnt_d    = 3'd0;
               if (!idSupported) begin
                  state_d  = ST_DRAIN;
                  cmdErr_d = 1'b1;
                  errId_d  = s_axis_tdata;
               end else if (idLen == 3'd0) begin
                  state_d = ST_OUT;
               end else begin
                  state_d = ST_ARGS;
               end
            end
         end

         ST_ARGS: begin
            if (accept) begin
               case (cnt_q)
                  3'd0:    cmdArg_d[7:0]   = s_axis_tdata;
                  3'd1:    cmdArg_d[15:8]  = s_axis_tdata;
                  3'd2:    cmdArg_d[23:16] = s_axis_tdata;
                  3'd3:    cmdArg_d[31:24] = s_axis_tdata;
                  default: cmdArg_d[39:32] = s_axis_tdata;
               endcase
               // The counter stops on the last argument index. It never
               // moves past len-1, which means it never exceeds 4.
               if (cnt_q == cmdLen_q - 3'd1) begin
                  state_d = ST_OUT;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end

         ST_OUT: begin
            if (cmd_ready) begin
               state_d = ST_IDLE;
            end
         end

         ST_DRAIN: begin
            // A byte that is still being offered is consumed even if the FIFO
            // already reports empty. Leave only once the stream is quiet.
            if (src_empty && !s_axis_tvaild) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      tready_d   = (state_d != ST_OUT);
      cmdValid_d = (state_d == ST_OUT);
   end

   // State and output registers with synchronous active-low reset. During
   // reset tready is held low. It rises on the first edge after resetn
   // returns high, and any partial or pending command is dropped.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         tready_q   <= 1'b0;
         cmdValid_q <= 1'b0;
         cmdId_q    <= 8'd0;
         cmdLen_q   <= 3'd0;
         cmdArg_q   <= 40'd0;
         cmdErr_q   <= 1'b0;
         errId_q    <= 8'd0;
         cnt_q      <= 3'd0;
      end else begin
         state_q    <= state_d;
         tready_q   <= tready_d;
         cmdValid_q <= cmdValid_d;
         cmdId_q    <= cmdId_d;
         cmdLen_q   <= cmdLen_d;
         cmdArg_q   <= cmdArg_d;
         cmdErr_q   <= cmdErr_d;
         errId_q    <= errId_d;
         cnt_q      <= cnt_d;
      end
   end

   assign s_axis_tready = tready_q;
   assign cmd_valid     = cmdValid_q;
   assign cmd_id        = cmdId_q;
   assign cmd_len       = cmdLen_q;
   assign cmd_arg       = cmdArg_q;
   assign cmd_err       = cmdErr_q;
   assign err_id        = errId_q;

endmodule

// File: tb/tb_dap_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_dap_cmd_decoder
//
// Directed bench for dap_cmd_decoder. Inputs change on the falling edge.
// The DUT samples them on the rising edge, and outputs are checked on the
// following falling edge. Expected values are hand-computed from the
// command table.
// ---------------------------------------------------------------------------
module tb_dap_cmd_decoder;

   logic        clk;
   logic        resetn;
   logic        s_axis_tvaild;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tready;
   logic        src_empty;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_id;
   logic [2:0]  cmd_len;
   logic [39:0] cmd_arg;
   logic        cmd_err;
   logic [7:0]  err_id;

   int vectors;
   int miscompares;

   dap_cmd_decoder dut (
      .clk           (clk),
      .resetn        (resetn),
      .s_axis_tvaild (s_axis_tvaild),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tready (s_axis_tready),
      .src_empty     (src_empty),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_id        (cmd_id),
      .cmd_len       (cmd_len),
      .cmd_arg       (cmd_arg),
      .cmd_err       (cmd_err),
      .err_id        (err_id)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive the stream and handshake inputs, then advance one full cycle.
   // On return the outputs reflect the edge that sampled these inputs.
   task automatic applyStimulus(input logic vld, input logic [7:0] data,
                                input logic empty, input logic rdy);
      s_axis_tvaild = vld;
      s_axis_tdata  = data;
      src_empty     = empty;
      cmd_ready     = rdy;
      @(posedge clk);
      @(negedge clk);
   endtask

   // One comparison point: count it, and on a miss count and report it.
   task automatic checkOutput(input string tag, input logic [39:0] observed,
                              input logic [39:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Linear sequence of directed steps.
   initial begin
      vectors       = 0;
      miscompares   = 0;
      resetn        = 1'b0;
      s_axis_tvaild = 1'b0;
      s_axis_tdata  = 8'h00;
      src_empty     = 1'b0;
      cmd_ready     = 1'b0;

      // Reset held low for four edges, then all outputs should be zero.
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_tready", 40'(s_axis_tready), 40'd0);
      checkOutput("rst_valid",  40'(cmd_valid),     40'd0);
      checkOutput("rst_id",     40'(cmd_id),        40'd0);
      checkOutput("rst_len",    40'(cmd_len),       40'd0);
      checkOutput("rst_arg",    cmd_arg,            40'd0);
      checkOutput("rst_err",    40'(cmd_err),       40'd0);
      checkOutput("rst_errid",  40'(err_id),        40'd0);

      // Release reset. tready rises only after the first edge that sees
      // resetn high.
      resetn = 1'b1;
      #1;
      checkOutput("rel_tready_lo", 40'(s_axis_tready), 40'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("rel_tready_hi", 40'(s_axis_tready), 40'd1);

      // Fixed-length decode: 0x11 takes 4 argument bytes.
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
      checkOutput("fix_id",     40'(cmd_id),    40'h11);
      checkOutput("fix_len",    40'(cmd_len),   40'd4);
      checkOutput("fix_nov0",   40'(cmd_valid), 40'd0);
      applyStimulus(1'b1, 8'h40, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h42, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h0F, 1'b0, 1'b1);
      checkOutput("fix_nov3",   40'(cmd_valid), 40'd0);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
      checkOutput("fix_valid",  40'(cmd_valid),     40'd1);
      checkOutput("fix_tready", 40'(s_axis_tready), 40'd0);
      checkOutput("fix_arg",    cmd_arg,            40'h00_000F4240);
      checkOutput("fix_id2",    40'(cmd_id),        40'h11);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("fix_done",   40'(cmd_valid),     40'd0);
      checkOutput("fix_idle",   40'(s_axis_tready), 40'd1);

      // Zero-length commands back to back with tvaild held high.
      applyStimulus(1'b1, 8'h03, 1'b0, 1'b1);
      checkOutput("z03_valid",  40'(cmd_valid),     40'd1);
      checkOutput("z03_id",     40'(cmd_id),        40'h03);
      checkOutput("z03_len",    40'(cmd_len),       40'd0);
      checkOutput("z03_arg",    cmd_arg,            40'd0);
      checkOutput("z03_tready", 40'(s_axis_tready), 40'd0);
      applyStimulus(1'b1, 8'h0A, 1'b0, 1'b1);
      checkOutput("z_gap_valid",  40'(cmd_valid),     40'd0);
      checkOutput("z_gap_tready", 40'(s_axis_tready), 40'd1);
      applyStimulus(1'b1, 8'h0A, 1'b0, 1'b1);
      checkOutput("z0a_valid",  40'(cmd_valid), 40'd1);
      checkOutput("z0a_id",     40'(cmd_id),    40'h0A);
      checkOutput("z0a_len",    40'(cmd_len),   40'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("z0a_done",   40'(cmd_valid), 40'd0);

      // Backpressure: 0x09 with two bytes, executor not ready for 6 cycles.
      applyStimulus(1'b1, 8'h09, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h34, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
      checkOutput("bp_len", 40'(cmd_len), 40'd2);
      for (int i = 0; i < 6; i++) begin
         checkOutput($sformatf("bp_valid%0d", i),  40'(cmd_valid),     40'd1);
         checkOutput($sformatf("bp_arg%0d", i),    cmd_arg,            40'h1234);
         checkOutput($sformatf("bp_tready%0d", i), 40'(s_axis_tready), 40'd0);
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      end
      checkOutput("bp_hold", 40'(cmd_valid), 40'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("bp_hs_valid",  40'(cmd_valid),     40'd0);
      checkOutput("bp_hs_tready", 40'(s_axis_tready), 40'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("bp_after", 40'(cmd_valid), 40'd0);

      // Stall in ARGS: 0x04 and five bytes, each byte preceded by a
      // 3-cycle gap in tvaild.
      applyStimulus(1'b1, 8'h04, 1'b0, 1'b1);
      for (int b = 0; b < 5; b++) begin
         repeat (3) applyStimulus(1'b0, 8'hEE, 1'b0, 1'b1);
         checkOutput($sformatf("st_nov%0d", b), 40'(cmd_valid), 40'd0);
         applyStimulus(1'b1, 8'(8'h11 * (b + 1)), 1'b0, 1'b1);
      end
      checkOutput("st_valid", 40'(cmd_valid), 40'd1);
      checkOutput("st_len",   40'(cmd_len),   40'd5);
      checkOutput("st_arg",   cmd_arg,        40'h55_44332211);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("st_done",  40'(cmd_valid), 40'd0);

      // Unsupported ID 0x05 followed by two trailing bytes, then FIFO empty.
      applyStimulus(1'b1, 8'h05, 1'b0, 1'b1);
      checkOutput("u05_err",    40'(cmd_err),       40'd1);
      checkOutput("u05_errid",  40'(err_id),        40'h05);
      checkOutput("u05_valid",  40'(cmd_valid),     40'd0);
      checkOutput("u05_tready", 40'(s_axis_tready), 40'd1);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
      checkOutput("u05_errlo",  40'(cmd_err),       40'd0);
      checkOutput("u05_tr1",    40'(s_axis_tready), 40'd1);
      applyStimulus(1'b1, 8'h01, 1'b1, 1'b1);
      checkOutput("u05_novld",  40'(cmd_valid),     40'd0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      checkOutput("u05_idle_v", 40'(cmd_valid),     40'd0);
      checkOutput("u05_idle_e", 40'(cmd_err),       40'd0);
      checkOutput("u05_hold",   40'(err_id),        40'h05);
      // A normal command afterwards decodes correctly.
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h01, 1'b0, 1'b1);
      checkOutput("n00_valid", 40'(cmd_valid), 40'd1);
      checkOutput("n00_id",    40'(cmd_id),    40'h00);
      checkOutput("n00_len",   40'(cmd_len),   40'd1);
      checkOutput("n00_arg",   cmd_arg,        40'h01);
      checkOutput("n00_errid", 40'(err_id),    40'h05);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

      // Drain consumes a valid byte even when the FIFO reports empty.
      // A 0x03 offered then must not become a command.
      applyStimulus(1'b1, 8'h07, 1'b0, 1'b1);
      checkOutput("u07_err",   40'(cmd_err), 40'd1);
      checkOutput("u07_errid", 40'(err_id),  40'h07);
      applyStimulus(1'b1, 8'h03, 1'b1, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      checkOutput("u07_novld", 40'(cmd_valid), 40'd0);
      checkOutput("u07_id",    40'(cmd_id),    40'h07);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("u07_novld2", 40'(cmd_valid), 40'd0);

      // Reset while a command is held in OUT drops it.
      applyStimulus(1'b1, 8'h0A, 1'b0, 1'b0);
      checkOutput("ro_valid", 40'(cmd_valid), 40'd1);
      resetn = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("ro_drop",   40'(cmd_valid),     40'd0);
      checkOutput("ro_tready", 40'(s_axis_tready), 40'd0);
      checkOutput("ro_id",     40'(cmd_id),        40'd0);
      checkOutput("ro_errid",  40'(err_id),        40'd0);
      resetn = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("ro_tready_hi", 40'(s_axis_tready), 40'd1);
      checkOutput("ro_valid_lo",  40'(cmd_valid),     40'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Safety net so the run always ends, even if time stops advancing as
   // expected.
   initial begin
      #100000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/dap_cmd_decoder.md
# dap_cmd_decoder

Request-side command decoder for the CMSIS-DAP datapath, directly downstream of the USB receiver's byte-wide AXI-Stream output. It takes one command byte plus that command's fixed-length argument bytes from the stream and presents them as a single parallel command word to the DAP executor through a valid/ready handshake. An unsupported command ID raises an error pulse, and the rest of the USB packet is drained using the receiver's FIFO-empty flag.

## Interface
Parameters:
- none; the command table below is fixed.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- s_axis_tvaild  in  1  byte valid from the receiver.
- s_axis_tdata  in  8  request byte.
- s_axis_tready  out  1  byte accepted when tready && tvaild at a clock edge.
- src_empty  in  1  receiver FIFO empty flag; used only in DRAIN.
- cmd_valid  out  1  decoded command available.
- cmd_ready  in  1  executor accepts the command.
- cmd_id  out  8  command ID byte.
- cmd_len  out  3  number of argument bytes, 0..5.
- cmd_arg  out  40  argument bytes, little-endian: byte k is in bits [8k+7:8k]. Bytes at index ≥ cmd_len read 0.
- cmd_err  out  1  one-cycle pulse when an unsupported ID is accepted.
- err_id  out  8  last unsupported ID; holds until the next error.

## Operation
Command table (ID → argument byte count):
- 0x00 → 1; 0x01 → 2; 0x02 → 1; 0x03 → 0; 0x04 → 5; 0x08 → 5; 0x09 → 2; 0x0A → 0; 0x11 → 4; 0x13 → 1.
- Every other ID is unsupported.

States:
- IDLE: s_axis_tready = 1. On accepting a byte:
  - Latch it into cmd_id, clear cmd_arg, clear the argument counter.
  - Supported ID with len > 0 → ARGS.
  - Supported ID with len = 0 → OUT.
  - Unsupported ID → DRAIN; cmd_err pulses; err_id is loaded.
- ARGS: s_axis_tready = 1.
  - Each accepted byte is stored at arg[cnt]; cnt increments.
  - On accepting byte cnt = len−1 → OUT.
  - Gaps in tvaild stall the state; there is no timeout.
- OUT: s_axis_tready = 0; cmd_valid = 1.
  - cmd_id, cmd_len and cmd_arg are stable while cmd_valid is high.
  - On cmd_valid && cmd_ready → IDLE.
- DRAIN: s_axis_tready = 1; accepted bytes are discarded.
  - Exit to IDLE on the first cycle where src_empty = 1 and s_axis_tvaild = 0.

Other rules:
- cmd_len is a 3-bit table lookup registered together with cmd_id.
- cnt is 3 bits and never exceeds 4; there is no wrap.
- Reset mid-operation returns the block to IDLE and discards any partial command. A command held in OUT is dropped; cmd_valid falls on the edge after resetn is sampled low.

## Timing
- Reset values: s_axis_tready = 0, cmd_valid = 0, cmd_id = 0, cmd_len = 0, cmd_arg = 0, cmd_err = 0, err_id = 0. State = IDLE; tready rises 1 cycle after resetn returns high.
- All outputs are registered; s_axis_tready is decoded from the state register only.
- Latency: cmd_valid rises 1 cycle after the last argument byte is accepted. For len = 0 commands, it rises 1 cycle after the ID byte is accepted.
- With cmd_ready held high, OUT lasts exactly 1 cycle, and IDLE accepts the next ID on the following edge.
- Best-case throughput for an n-argument command is n+2 cycles.
- cmd_err is high for exactly the cycle after the unsupported ID is accepted. That cycle is the first cycle of DRAIN.
- In DRAIN, a byte with tvaild = 1 is consumed even if src_empty = 1 in the same cycle; exit waits for tvaild = 0.
- cmd_ready is ignored outside OUT. cmd_valid never drops without a handshake, except on reset.

## Test plan
- Reset then idle: hold resetn low for 4 cycles → all outputs 0; tready = 1 on the 2nd cycle after release.
- Fixed-length decode: stream 0x11,0x40,0x42,0x0F,0x00 with cmd_ready = 1 → one cmd_valid pulse with cmd_id = 0x11, cmd_len = 4, cmd_arg = 0x00_000F4240 (byte 4 = 0), 1 cycle after the 5th byte is accepted.
- Zero-length and back-to-back: stream 0x03 then 0x0A with tvaild held high → two commands with len = 0; tready is low only during each OUT cycle; no byte is lost.
- Backpressure:
  - Send 0x09,0x34,0x12 with cmd_ready = 0 for 6 cycles → cmd_valid held, cmd_arg = 0x1234 stable, tready = 0 throughout.
  - Raise cmd_ready → single handshake, then IDLE.
- Stall in ARGS: 0x04 followed by 5 bytes with 3-cycle tvaild gaps → correct 5-byte cmd_arg; no early cmd_valid.
- Unsupported ID: 0x05,0x00,0x01 with src_empty = 1 after the last byte → cmd_err pulses once with err_id = 0x05, both trailing bytes are consumed, no cmd_valid, return to IDLE. A subsequent 0x00,0x01 then decodes normally.
